// File: rtl/ports_slice.sv
// ports_slice: per-channel 2-entry skid buffer with fully registered outputs
// and a saturating transfer counter per channel.
module ports_slice #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CTRL_BITS = 8,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             s__valid,
    output logic [NUM_CH-1:0]             s__ready,
    input  logic [NUM_CH*CTRL_BITS-1:0]   s__ctrl,
    input  logic [NUM_CH*DATA_BITS-1:0]   s__data,
    output logic [NUM_CH-1:0]             t__valid,
    input  logic [NUM_CH-1:0]             t__ready,
    output logic [NUM_CH*CTRL_BITS-1:0]   t__ctrl,
    output logic [NUM_CH*DATA_BITS-1:0]   t__data,
    input  logic                          clr,
    output logic [NUM_CH*CNT_BITS-1:0]    xfer_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e                 state_q, state_d;
        logic [CTRL_BITS-1:0]   main_ctrl_q, main_ctrl_d;
        logic [DATA_BITS-1:0]   main_data_q, main_data_d;
        logic [CTRL_BITS-1:0]   skid_ctrl_q, skid_ctrl_d;
        logic [DATA_BITS-1:0]   skid_data_q, skid_data_d;
        logic                   valid_q, valid_d;
        logic                   ready_q, ready_d;
        logic [CNT_BITS-1:0]    cnt_q, cnt_d;
        logic                   push_c, pop_c;
        logic [CTRL_BITS-1:0]   in_ctrl_c;
        logic [DATA_BITS-1:0]   in_data_c;

        assign in_ctrl_c = s__ctrl[g*CTRL_BITS +: CTRL_BITS];
        assign in_data_c = s__data[g*DATA_BITS +: DATA_BITS];
        assign push_c    = s__valid[g] & ready_q;
        assign pop_c     = valid_q & t__ready[g];

        // Next-state, storage moves, registered handshake outputs and counter
        always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            cnt_d       = cnt_q;

            case (state_q)
                ST_EMPTY: begin
                    if (push_c) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl_c;
                        main_data_d = in_data_c;
                    end
                end
                ST_ONE: begin
                    if (push_c && pop_c) begin
                        main_ctrl_d = in_ctrl_c;
                        main_data_d = in_data_c;
                    end else if (push_c) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl_c;
                        skid_data_d = in_data_c;
                    end else if (pop_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop_c) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase

            // Handshake outputs are precomputed from the next state so they come straight from flops
            valid_d = (state_d != ST_EMPTY);
            ready_d = (state_d != ST_TWO);

            if (clr) begin
                cnt_d = '0;
            end else if (pop_c && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end

        // State and datapath registers; ready_q stays low until the first edge after reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= ST_EMPTY;
                main_ctrl_q <= '0;
                main_data_q <= '0;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
                valid_q     <= 1'b0;
                ready_q     <= 1'b0;
                cnt_q       <= '0;
            end else begin
                state_q     <= state_d;
                main_ctrl_q <= main_ctrl_d;
                main_data_q <= main_data_d;
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
                valid_q     <= valid_d;
                ready_q     <= ready_d;
                cnt_q       <= cnt_d;
            end
        end

        assign s__ready[g]                         = ready_q;
        assign t__valid[g]                         = valid_q;
        assign t__ctrl[g*CTRL_BITS +: CTRL_BITS]   = main_ctrl_q;
        assign t__data[g*DATA_BITS +: DATA_BITS]   = main_data_q;
        assign xfer_cnt[g*CNT_BITS +: CNT_BITS]    = cnt_q;
    end

endmodule
